mac_rx: RTL and testbench

MAC_RX -- requirements
Module: mac_rx

---
 rtl/mac_rx_pkg.sv | 30 +++
 rtl/mac_crc32.sv | 23 ++
 rtl/mac_rx.sv | 206 ++++++++++++++++++++
 tb/tb_mac_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_rx_pkg.sv
// rtl/mac_rx_pkg.sv - shared encodings and constants for the RMII receive MAC
package mac_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_DISCARD
  } state_t;

  localparam logic [15:0] ETHERTYPE_MAGIC = 16'h5139;
  localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE     = 32'hDEBB20E3;
  localparam logic [47:0] BCAST_MAC       = 48'hFFFF_FFFF_FFFF;
  localparam logic [1:0]  DIBIT_PRE       = 2'b01;
  localparam logic [1:0]  DIBIT_SFD       = 2'b11;
  localparam logic [3:0]  HDR_LAST        = 4'd15;

  // Reflected CRC-32 step over one dibit, bit 0 first
  function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] dibit);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      c = (c[0] ^ dibit[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_crc32.sv
// rtl/mac_crc32.sv - per-dibit CRC-32 register with init and enable
module mac_crc32
  import mac_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 32'hFFFF_FFFF;
    end else if (init) begin
      crc <= 32'hFFFF_FFFF;
    end else if (en) begin
      crc <= crc32_dibit(crc, dibit);
    end
  end

endmodule

// File: rtl/mac_rx.sv
// rtl/mac_rx.sv - RMII receive MAC: header filter, held-back word writes, commit/drop
module mac_rx
  import mac_rx_pkg::*;
#(
  parameter int MAC_PACKET_BITS = 9,
  parameter int MAX_PACKET      = 375
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx0,
  input  logic                       rx1,
  input  logic                       crs_dv,
  input  logic [47:0]                own_mac,
  output logic [31:0]                rxq_data,
  output logic                       rxq_wr_en,
  input  logic                       rxq_full,
  output logic [MAC_PACKET_BITS-1:0] rxq_len,
  output logic [15:0]                rxq_seq,
  output logic                       rxq_commit,
  output logic                       rxq_drop,
  output logic [15:0]                cnt_good,
  output logic [15:0]                cnt_crc_err,
  output logic [15:0]                cnt_drop
);

  localparam logic [MAC_PACKET_BITS-1:0] MAX_WORDS = MAC_PACKET_BITS'(MAX_PACKET);

  state_t state, state_d;

  logic [1:0]  dibit;
  logic        dv_q;
  logic        eof;
  logic        in_frame;
  logic        byte_done;
  logic        word_done;
  logic [1:0]  dib_cnt;
  logic [1:0]  bw_cnt;
  logic [3:0]  hdr_cnt;
  logic [5:0]  byte_sr;
  logic [7:0]  full_byte;
  logic [47:0] mac_sr;
  logic        own_ok, bc_ok, eth_ok;
  logic [15:0] seq_sr;
  logic [23:0] word_sr;
  logic [31:0] new_word;
  logic [31:0] hold;
  logic        have_hold;
  logic [MAC_PACKET_BITS-1:0] wr_cnt;
  logic [31:0] crc;

  logic do_write, do_commit, do_drop, inc_good, inc_crc, inc_drop;

  assign dibit     = {rx1, rx0};
  assign eof       = !crs_dv && !dv_q;
  assign in_frame  = (state == ST_HEADER) || (state == ST_PAYLOAD);
  assign byte_done = crs_dv && in_frame && (dib_cnt == 2'd3);
  assign word_done = byte_done && (state == ST_PAYLOAD) && (bw_cnt == 2'd3);
  assign full_byte = {dibit, byte_sr};
  assign new_word  = {word_sr, full_byte};

  mac_crc32 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (!in_frame),
    .en    (crs_dv && in_frame),
    .dibit (dibit),
    .crc   (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    do_write  = 1'b0;
    do_commit = 1'b0;
    do_drop   = 1'b0;
    inc_good  = 1'b0;
    inc_crc   = 1'b0;
    inc_drop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (crs_dv && dibit == DIBIT_PRE) state_d = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (eof) state_d = ST_IDLE;
        else if (crs_dv) begin
          if (dibit == DIBIT_SFD)      state_d = ST_HEADER;
          else if (dibit != DIBIT_PRE) state_d = ST_DISCARD;
        end
      end
      ST_HEADER: begin
        if (eof) state_d = ST_IDLE;
        else if (byte_done && hdr_cnt == HDR_LAST)
          state_d = ((own_ok || bc_ok) && eth_ok) ? ST_PAYLOAD : ST_DISCARD;
      end
      ST_PAYLOAD: begin
        if (eof) begin
          state_d = ST_IDLE;
          // Alignment and length take precedence over the CRC verdict
          if (dib_cnt != 2'd0 || bw_cnt != 2'd0 || wr_cnt == '0) begin
            do_drop  = (wr_cnt != '0);
            inc_drop = 1'b1;
          end else if (crc != CRC_RESIDUE) begin
            do_drop = 1'b1;
            inc_crc = 1'b1;
          end else begin
            do_commit = 1'b1;
            inc_good  = 1'b1;
          end
        end else if (word_done && have_hold) begin
          if (rxq_full || wr_cnt >= MAX_WORDS) begin
            state_d  = ST_DISCARD;
            do_drop  = (wr_cnt != '0);
            inc_drop = 1'b1;
          end else begin
            do_write = 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        if (eof) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q        <= 1'b0;
      rxq_wr_en   <= 1'b0;
      rxq_commit  <= 1'b0;
      rxq_drop    <= 1'b0;
      rxq_data    <= '0;
      rxq_len     <= '0;
      rxq_seq     <= '0;
      cnt_good    <= '0;
      cnt_crc_err <= '0;
      cnt_drop    <= '0;
      dib_cnt     <= '0;
      bw_cnt      <= '0;
      hdr_cnt     <= '0;
      byte_sr     <= '0;
      mac_sr      <= '0;
      own_ok      <= 1'b0;
      bc_ok       <= 1'b0;
      eth_ok      <= 1'b0;
      seq_sr      <= '0;
      word_sr     <= '0;
      hold        <= '0;
      have_hold   <= 1'b0;
      wr_cnt      <= '0;
    end else begin
      dv_q       <= crs_dv;
      rxq_wr_en  <= do_write;
      rxq_commit <= do_commit;
      rxq_drop   <= do_drop;
      if (do_write) rxq_data <= hold;
      if (do_commit) begin
        rxq_len <= wr_cnt;
        rxq_seq <= seq_sr;
      end
      if (inc_good && cnt_good    != 16'hFFFF) cnt_good    <= cnt_good + 16'd1;
      if (inc_crc  && cnt_crc_err != 16'hFFFF) cnt_crc_err <= cnt_crc_err + 16'd1;
      if (inc_drop && cnt_drop    != 16'hFFFF) cnt_drop    <= cnt_drop + 16'd1;

      if (!in_frame) begin
        dib_cnt   <= '0;
        bw_cnt    <= '0;
        hdr_cnt   <= '0;
        have_hold <= 1'b0;
        wr_cnt    <= '0;
        own_ok    <= 1'b1;
        bc_ok     <= 1'b1;
        eth_ok    <= 1'b1;
        mac_sr    <= own_mac;
      end else if (crs_dv) begin
        dib_cnt <= dib_cnt + 2'd1;
        byte_sr <= {dibit, byte_sr[5:2]};
        if (byte_done && state == ST_HEADER) begin
          hdr_cnt <= hdr_cnt + 4'd1;
          if (hdr_cnt < 4'd6) begin
            if (full_byte != mac_sr[47:40])    own_ok <= 1'b0;
            if (full_byte != BCAST_MAC[47:40]) bc_ok  <= 1'b0;
            mac_sr <= {mac_sr[39:0], 8'h00};
          end
          if (hdr_cnt == 4'd12 && full_byte != ETHERTYPE_MAGIC[15:8]) eth_ok <= 1'b0;
          if (hdr_cnt == 4'd13 && full_byte != ETHERTYPE_MAGIC[7:0])  eth_ok <= 1'b0;
          // The last two header bytes left in here are the sequence field
          seq_sr <= {seq_sr[7:0], full_byte};
        end else if (byte_done) begin
          bw_cnt  <= bw_cnt + 2'd1;
          word_sr <= {word_sr[15:0], full_byte};
          if (word_done) begin
            hold      <= new_word;
            have_hold <= 1'b1;
          end
          if (do_write) wr_cnt <= wr_cnt + MAC_PACKET_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_rx.sv
// tb/tb_mac_rx.sv - table-driven bench for mac_rx
`timescale 1ns/1ps
module tb_mac_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx0 = 1'b0, rx1 = 1'b0, crs_dv = 1'b0, rxq_full = 1'b0;
  logic [47:0] own_mac = 48'h0200_0000_0002;
  logic [31:0] rxq_data;
  logic        rxq_wr_en, rxq_commit, rxq_drop;
  logic [8:0]  rxq_len;
  logic [15:0] rxq_seq, cnt_good, cnt_crc_err, cnt_drop;

  mac_rx #(.MAC_PACKET_BITS(9), .MAX_PACKET(375)) dut (
    .clk(clk), .rst_n(rst_n), .rx0(rx0), .rx1(rx1), .crs_dv(crs_dv),
    .own_mac(own_mac), .rxq_data(rxq_data), .rxq_wr_en(rxq_wr_en),
    .rxq_full(rxq_full), .rxq_len(rxq_len), .rxq_seq(rxq_seq),
    .rxq_commit(rxq_commit), .rxq_drop(rxq_drop), .cnt_good(cnt_good),
    .cnt_crc_err(cnt_crc_err), .cnt_drop(cnt_drop)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [47:0] dst;
    logic [15:0] eth;
    logic [15:0] seq;
    int          nwords;
    int          extra;
    bit          flip;
    int          full_word;
    int          dropout;
    int          exp_wr;
    int          exp_commit;
    int          exp_drop;
    int          exp_good;
    int          exp_crc;
    int          exp_dcnt;
  } vec_t;

  vec_t tbl [11];

  int errors = 0;
  int checks = 0;

  logic [31:0] wr_q [$];
  int          n_commit = 0, n_drop = 0, commit_cyc = 0, fall_cyc = 0;
  logic [8:0]  got_len = '0;
  logic [15:0] got_seq = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rxq_wr_en) wr_q.push_back(rxq_data);
      if (rxq_commit) begin
        n_commit++;
        commit_cyc = cyc;
        got_len    = rxq_len;
        got_seq    = rxq_seq;
      end
      if (rxq_drop) n_drop++;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [31:0] pw(input int k);
    if (k == 0) return 32'h1122_3344;
    if (k == 1) return 32'h5566_7788;
    return {16'hC0DE, k[15:0]};
  endfunction

  task automatic send_frame(input vec_t v, input int cut);
    logic [7:0]  bq [$];
    logic [31:0] c, w;
    logic [47:0] src;
    int          di;
    src = 48'h0211_2233_4455;
    repeat (7) bq.push_back(8'h55);
    bq.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) bq.push_back(v.dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) bq.push_back(src[8*i +: 8]);
    bq.push_back(v.eth[15:8]); bq.push_back(v.eth[7:0]);
    bq.push_back(v.seq[15:8]); bq.push_back(v.seq[7:0]);
    for (int k = 0; k < v.nwords; k++) begin
      w = pw(k);
      bq.push_back(w[31:24]); bq.push_back(w[23:16]);
      bq.push_back(w[15:8]);  bq.push_back(w[7:0]);
    end
    repeat (v.extra) bq.push_back(8'hAA);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < bq.size(); i++) c = crc_byte(c, bq[i]);
    c = ~c;
    bq.push_back(c[7:0] ^ {7'h0, v.flip});
    bq.push_back(c[15:8]); bq.push_back(c[23:16]); bq.push_back(c[31:24]);
    di = 0;
    for (int i = 0; i < bq.size(); i++) begin
      for (int d = 0; d < 4; d++) begin
        if (di == cut) begin
          @(negedge clk);
          rst_n = 1'b0; crs_dv = 1'b0; rxq_full = 1'b0;
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          repeat (4) @(negedge clk);
          return;
        end
        if (di == v.dropout) begin
          @(negedge clk);
          crs_dv = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
        end
        @(negedge clk);
        crs_dv   = 1'b1;
        rx0      = bq[i][2*d];
        rx1      = bq[i][2*d+1];
        rxq_full = (v.full_word >= 0 && i >= 24 && (i - 24) / 4 == v.full_word);
        di++;
      end
    end
    @(negedge clk);
    crs_dv = 1'b0; rx0 = 1'b0; rx1 = 1'b0; rxq_full = 1'b0;
    fall_cyc = cyc;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int base_wr, base_commit, base_drop, nw;
    //            dst                 eth       seq      nw   ex flip full drop  wr   c  d  good crc dcnt
    tbl[0]  = '{48'h0200_0000_0002, 16'h5139, 16'h0007,   2, 0, 1'b0, -1,  -1,   2, 1, 0, 1, 0, 0};
    tbl[1]  = '{48'h0200_0000_0002, 16'h5139, 16'h0007,   2, 0, 1'b1, -1,  -1,   2, 0, 1, 1, 1, 0};
    tbl[2]  = '{48'h0200_0000_0001, 16'h5139, 16'h0007,   2, 0, 1'b0, -1,  -1,   0, 0, 0, 1, 1, 0};
    tbl[3]  = '{48'h0200_0000_0002, 16'h0800, 16'h0007,   2, 0, 1'b0, -1,  -1,   0, 0, 0, 1, 1, 0};
    tbl[4]  = '{48'hFFFF_FFFF_FFFF, 16'h5139, 16'h0010, 376, 0, 1'b0, -1,  -1, 375, 0, 1, 1, 1, 1};
    tbl[5]  = '{48'hFFFF_FFFF_FFFF, 16'h5139, 16'h1234,   3, 0, 1'b0, -1,  -1,   3, 1, 0, 2, 1, 1};
    tbl[6]  = '{48'h0200_0000_0002, 16'h5139, 16'h0020,   2, 2, 1'b0, -1,  -1,   2, 0, 1, 2, 1, 2};
    tbl[7]  = '{48'h0200_0000_0002, 16'h5139, 16'h0021,   4, 0, 1'b0,  3,  -1,   2, 0, 1, 2, 1, 3};
    tbl[8]  = '{48'h0200_0000_0002, 16'h5139, 16'h0022,   0, 0, 1'b0, -1,  -1,   0, 0, 0, 2, 1, 4};
    tbl[9]  = '{48'h0200_0000_0002, 16'h5139, 16'hBEEF,   2, 0, 1'b0, -1, 100,   2, 1, 0, 3, 1, 4};
    tbl[10] = '{48'h0200_0000_0002, 16'h5139, 16'h0001,   1, 0, 1'b0, -1,  -1,   1, 1, 0, 4, 1, 4};

    repeat (3) @(negedge clk);
    chk("rst_wr_en", rxq_wr_en, 0);
    chk("rst_commit", rxq_commit, 0);
    chk("rst_drop", rxq_drop, 0);
    chk("rst_len", rxq_len, 0);
    chk("rst_seq", rxq_seq, 0);
    chk("rst_cnts", {cnt_good, cnt_crc_err, cnt_drop}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 11; v++) begin
      base_wr = wr_q.size(); base_commit = n_commit; base_drop = n_drop;
      send_frame(tbl[v], -1);
      nw = wr_q.size() - base_wr;
      chk($sformatf("v%0d_writes", v), nw, tbl[v].exp_wr);
      for (int k = 0; k < nw && k < tbl[v].exp_wr; k++)
        chk($sformatf("v%0d_data%0d", v, k), wr_q[base_wr + k], pw(k));
      chk($sformatf("v%0d_commit", v), n_commit - base_commit, tbl[v].exp_commit);
      chk($sformatf("v%0d_drop", v), n_drop - base_drop, tbl[v].exp_drop);
      if (tbl[v].exp_commit != 0 && n_commit != base_commit) begin
        chk($sformatf("v%0d_len", v), got_len, tbl[v].exp_wr);
        chk($sformatf("v%0d_seq", v), got_seq, tbl[v].seq);
        chk($sformatf("v%0d_latency", v), commit_cyc - fall_cyc, 2);
      end
      chk($sformatf("v%0d_cnt_good", v), cnt_good, tbl[v].exp_good);
      chk($sformatf("v%0d_cnt_crc", v), cnt_crc_err, tbl[v].exp_crc);
      chk($sformatf("v%0d_cnt_drop", v), cnt_drop, tbl[v].exp_dcnt);
    end

    // Reset in the middle of the third payload word, then a clean frame
    base_commit = n_commit; base_drop = n_drop;
    send_frame(tbl[0], 32 + 64 + 40);
    chk("midrst_commit", n_commit - base_commit, 0);
    chk("midrst_drop", n_drop - base_drop, 0);
    chk("midrst_cnts", {cnt_good, cnt_crc_err, cnt_drop}, 0);
    chk("midrst_len", rxq_len, 0);
    base_wr = wr_q.size(); base_commit = n_commit;
    send_frame(tbl[0], -1);
    chk("after_rst_writes", wr_q.size() - base_wr, 2);
    chk("after_rst_commit", n_commit - base_commit, 1);
    chk("after_rst_len", got_len, 2);
    chk("after_rst_seq", got_seq, 16'h0007);
    chk("after_rst_good", cnt_good, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
